// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage plus IF/ID pipeline register feeding the `control`
// decoder. Holds the PC, runs a req/ack handshake with instruction memory,
// keeps one overflow word in a hold buffer while decode is stalled, and
// handles branch redirects from execute.
//
// Optional feature macro: FETCH_DELAY_SLOT_EN
//   defined   -> a valid IF/ID entry survives a branch (MIPS delay slot)
//   undefined -> a branch clears the IF/ID entry
//
// Parameters:
//   RESET_PC       PC value after reset
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   imem_req       fetch request to instruction memory (high only in WAIT)
//   imem_addr      address being fetched (always equals the PC)
//   imem_ack       memory returns data this cycle (honoured only with imem_req)
//   imem_rdata     instruction word returned by memory
//   stall          decode cannot accept; IF/ID must hold
//   branch_taken   one-cycle redirect pulse from execute
//   branch_target  redirect address, sampled with branch_taken
//   inst_valid     IF/ID holds a valid instruction
//   inst_pc        address of the instruction in IF/ID
//   instruction    registered instruction word
//   inst_1         opcode field instruction[31:26]
//   inst_2         funct field instruction[5:0]
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] instruction,
  output logic [5:0]  inst_1,
  output logic [5:0]  inst_2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Current state
  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_word;
  logic [31:0] hold_pc;
  logic        redirect_pending;
  logic [31:0] redirect_pc;

  // Next state
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] hold_word_nxt;
  logic [31:0] hold_pc_nxt;
  logic        redirect_pending_nxt;
  logic [31:0] redirect_pc_nxt;
  logic        inst_valid_nxt;
  logic [31:0] inst_pc_nxt;
  logic [31:0] instruction_nxt;

  logic ack;
  logic consume;
  logic slot_free;

  // The request is purely a function of state, so a late ack arriving while
  // imem_req is low (IDLE, HOLD, or just after reset) is ignored.
  assign imem_req  = (state == WAIT);
  assign imem_addr = pc;
  assign inst_1    = instruction[31:26];
  assign inst_2    = instruction[5:0];

  assign ack       = imem_req && imem_ack;
  assign consume   = inst_valid && !stall;
  assign slot_free = !inst_valid || consume;

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nxt            = state;
    pc_nxt               = pc;
    hold_word_nxt        = hold_word;
    hold_pc_nxt          = hold_pc;
    redirect_pending_nxt = redirect_pending;
    redirect_pc_nxt      = redirect_pc;
    inst_valid_nxt       = consume ? 1'b0 : inst_valid;
    inst_pc_nxt          = inst_pc;
    instruction_nxt      = instruction;

    unique case (state)
      IDLE: begin
        state_nxt = WAIT;
        if (branch_taken) begin
          pc_nxt               = branch_target;
          redirect_pending_nxt = 1'b0;
        end
      end

      WAIT: begin
        if (branch_taken) begin
          if (ack) begin
            // Word returned for the old path is dropped; refetch at target.
            pc_nxt               = branch_target;
            redirect_pending_nxt = 1'b0;
          end else begin
            // The request in flight must complete at its current address,
            // so remember the target and redirect once the ack arrives.
            redirect_pc_nxt      = branch_target;
            redirect_pending_nxt = 1'b1;
          end
        end else if (ack) begin
          if (redirect_pending) begin
            pc_nxt               = redirect_pc;
            redirect_pending_nxt = 1'b0;
          end else if (slot_free) begin
            instruction_nxt = imem_rdata;
            inst_pc_nxt     = pc;
            inst_valid_nxt  = 1'b1;
            pc_nxt          = pc + 32'd4;
          end else begin
            // IF/ID is occupied and stalled: park the word until decode frees.
            hold_word_nxt = imem_rdata;
            hold_pc_nxt   = pc;
            pc_nxt        = pc + 32'd4;
            state_nxt     = HOLD;
          end
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_nxt               = branch_target;
          redirect_pending_nxt = 1'b0;
          state_nxt            = WAIT;
        end else if (!stall) begin
          instruction_nxt = hold_word;
          inst_pc_nxt     = hold_pc;
          inst_valid_nxt  = 1'b1;
          state_nxt       = WAIT;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (branch_taken) begin
`ifdef FETCH_DELAY_SLOT_EN
      // Delay slot: an entry not yet consumed stays visible to decode.
      inst_valid_nxt = inst_valid && !consume;
`else
      inst_valid_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of ordering.
    if (reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      hold_word        <= '0;
      hold_pc          <= '0;
      redirect_pending <= 1'b0;
      redirect_pc      <= '0;
      inst_valid       <= 1'b0;
      inst_pc          <= '0;
      instruction      <= '0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      hold_word        <= hold_word_nxt;
      hold_pc          <= hold_pc_nxt;
      redirect_pending <= redirect_pending_nxt;
      redirect_pc      <= redirect_pc_nxt;
      inst_valid       <= inst_valid_nxt;
      inst_pc          <= inst_pc_nxt;
      instruction      <= instruction_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed, table-driven bench for fetch_stage (default build, delay slot
// disabled). Each table row gives the inputs driven in one cycle and the
// outputs expected in that same cycle. Inputs are driven and outputs sampled
// on the falling edge; the DUT updates on the rising edge. Hand-written
// sequences afterwards cover PC wrap-around and back-to-back redirects.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] instruction;
  logic [5:0]  inst_1;
  logic [5:0]  inst_2;

  integer tests_run;
  integer tests_failed;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst_pc       (inst_pc),
    .instruction   (instruction),
    .inst_1        (inst_1),
    .inst_2        (inst_2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [5:0]  e_i1;
    logic [5:0]  e_i2;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vec [NVEC];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic stl, input logic br, input logic [31:0] tgt);
    reset         = rst;
    imem_ack      = ack;
    imem_rdata    = rdata;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //             rst ack rdata         stl br tgt           req addr          vld instr         ipc           i1     i2
    vec[0]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b0,32'h0,       1'b0,32'h0,        32'h0,        6'h00,6'h00};
    vec[1]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b0,32'h0,       1'b0,32'h0,        32'h0,        6'h00,6'h00};
    vec[2]  = '{1'b0,1'b1,32'h8C01_0004,1'b0,1'b0,32'h0,  1'b1,32'h0,       1'b0,32'h0,        32'h0,        6'h00,6'h00};
    vec[3]  = '{1'b0,1'b1,32'hAC01_0008,1'b0,1'b0,32'h0,  1'b1,32'h4,       1'b1,32'h8C01_0004,32'h0,        6'h23,6'h04};
    vec[4]  = '{1'b0,1'b1,32'h0022_1820,1'b0,1'b0,32'h0,  1'b1,32'h8,       1'b1,32'hAC01_0008,32'h4,        6'h2B,6'h08};
    vec[5]  = '{1'b0,1'b1,32'h0022_1822,1'b0,1'b0,32'h0,  1'b1,32'hC,       1'b1,32'h0022_1820,32'h8,        6'h00,6'h20};
    vec[6]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b1,32'h10,      1'b1,32'h0022_1822,32'hC,        6'h00,6'h22};
    vec[7]  = '{1'b0,1'b1,32'h1111_1111,1'b0,1'b0,32'h0,  1'b1,32'h10,      1'b0,32'h0022_1822,32'hC,        6'h00,6'h22};
    // Stall held three cycles while an ack arrives
    vec[8]  = '{1'b0,1'b1,32'h2222_2222,1'b1,1'b0,32'h0,  1'b1,32'h14,      1'b1,32'h1111_1111,32'h10,       6'h04,6'h11};
    vec[9]  = '{1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,  1'b0,32'h18,      1'b1,32'h1111_1111,32'h10,       6'h04,6'h11};
    vec[10] = '{1'b0,1'b1,32'hDEAD_BEEF,1'b1,1'b0,32'h0,  1'b0,32'h18,      1'b1,32'h1111_1111,32'h10,       6'h04,6'h11};
    vec[11] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b0,32'h18,      1'b1,32'h1111_1111,32'h10,       6'h04,6'h11};
    vec[12] = '{1'b0,1'b1,32'h3333_3333,1'b0,1'b0,32'h0,  1'b1,32'h18,      1'b1,32'h2222_2222,32'h14,       6'h08,6'h22};
    // Branch in WAIT with ack delayed two cycles
    vec[13] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h100,1'b1,32'h1C,      1'b1,32'h3333_3333,32'h18,       6'h0C,6'h33};
    vec[14] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b1,32'h1C,      1'b0,32'h3333_3333,32'h18,       6'h0C,6'h33};
    vec[15] = '{1'b0,1'b1,32'h4444_4444,1'b0,1'b0,32'h0,  1'b1,32'h1C,      1'b0,32'h3333_3333,32'h18,       6'h0C,6'h33};
    vec[16] = '{1'b0,1'b1,32'h5555_5555,1'b0,1'b0,32'h0,  1'b1,32'h100,     1'b0,32'h3333_3333,32'h18,       6'h0C,6'h33};
    // Branch and ack in the same cycle, target 0x20
    vec[17] = '{1'b0,1'b1,32'h6666_6666,1'b0,1'b1,32'h20, 1'b1,32'h104,     1'b1,32'h5555_5555,32'h100,      6'h15,6'h15};
    // Reset during WAIT with pc = 0x20, late ack while req is low
    vec[18] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b1,32'h20,      1'b0,32'h5555_5555,32'h100,      6'h15,6'h15};
    vec[19] = '{1'b0,1'b1,32'h7777_7777,1'b0,1'b0,32'h0,  1'b0,32'h0,       1'b0,32'h0,        32'h0,        6'h00,6'h00};
    vec[20] = '{1'b0,1'b1,32'h8C01_0004,1'b0,1'b0,32'h0,  1'b1,32'h0,       1'b0,32'h0,        32'h0,        6'h00,6'h00};
    vec[21] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b1,32'h4,       1'b1,32'h8C01_0004,32'h0,        6'h23,6'h04};

    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clock);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      check($sformatf("v%0d imem_req", i),    {31'h0, imem_req},   {31'h0, vec[i].e_req});
      check($sformatf("v%0d imem_addr", i),   imem_addr,           vec[i].e_addr);
      check($sformatf("v%0d inst_valid", i),  {31'h0, inst_valid}, {31'h0, vec[i].e_valid});
      check($sformatf("v%0d instruction", i), instruction,         vec[i].e_instr);
      check($sformatf("v%0d inst_pc", i),     inst_pc,             vec[i].e_ipc);
      check($sformatf("v%0d inst_1", i),      {26'h0, inst_1},     {26'h0, vec[i].e_i1});
      check($sformatf("v%0d inst_2", i),      {26'h0, inst_2},     {26'h0, vec[i].e_i2});
      drive(vec[i].rst, vec[i].ack, vec[i].rdata, vec[i].stl, vec[i].br, vec[i].tgt);
    end

    // PC wrap: branch+ack to 0xFFFF_FFFC, then fetch there; next pc wraps to 0.
    @(negedge clock);
    drive(1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b1, 32'hFFFF_FFFC);
    @(negedge clock);
    check("wrap addr_top",  imem_addr, 32'hFFFF_FFFC);
    check("wrap valid_cleared", {31'h0, inst_valid}, 32'h0);
    drive(1'b0, 1'b1, 32'hABCD_0000, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    check("wrap addr_zero", imem_addr, 32'h0);
    check("wrap inst_pc",   inst_pc,   32'hFFFF_FFFC);
    check("wrap instr",     instruction, 32'hABCD_0000);
    check("wrap valid",     {31'h0, inst_valid}, 32'h1);

    // Two branches while the redirect is pending: the second target wins.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    @(negedge clock);
    check("rebr addr_hold1", imem_addr, 32'h0);
    check("rebr valid",      {31'h0, inst_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    @(negedge clock);
    check("rebr addr_hold2", imem_addr, 32'h0);
    drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    check("rebr addr_new",   imem_addr, 32'h80);
    check("rebr req",        {31'h0, imem_req}, 32'h1);
    check("rebr dropped",    {31'h0, inst_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
